sentinel_access_ctrl: RTL and testbench

SENTINEL_ACCESS_CTRL -- requirements
Module: sentinel_access_ctrl

---
 rtl/sentinel_pkg.sv | 17 +
 rtl/sentinel_rr_arb.sv | 30 +++
 rtl/sentinel_access_ctrl.sv | 135 +++++++++++++
 tb/tb_sentinel_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sentinel_pkg.sv
// Shared types and parameter defaults for the Sentinel access controller.
package sentinel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CAPTURE,
        LOCKOUT
    } state_t;

    localparam int unsigned DEF_SETTLE_CYCLES  = 2;
    localparam logic [7:0]  DEF_UNLOCK_PATTERN = 8'hA5;
    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 16;

endpackage

// File: rtl/sentinel_rr_arb.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
module sentinel_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] winner
);

    logic favour;

    // With only two requesters, if the favoured one is idle the other is the sole requester.
    always_comb begin
        winner = 2'b00;
        if (req[favour]) begin
            winner = favour ? 2'b10 : 2'b01;
        end else if (req != 2'b00) begin
            winner = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour <= 1'b0;
        end else if (update && winner != 2'b00) begin
            favour <= winner[0];
        end
    end

endmodule

// File: rtl/sentinel_access_ctrl.sv
// Arbitrates two key requesters onto the Sentinel core, checks the unlock result
// and enforces a lockout after repeated failures.
module sentinel_access_ctrl
    import sentinel_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter logic [7:0]  UNLOCK_PATTERN = DEF_UNLOCK_PATTERN,
    parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] req,
    input  logic [7:0] key0,
    input  logic [7:0] key1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       pass,
    output logic [7:0] core_ui,
    input  logic [7:0] core_uo,
    output logic       lockout
);

    state_t     state, state_nxt;
    logic [1:0] arb_winner;
    logic [1:0] gnt_q;
    logic       arb_update;
    logic [7:0] key_q;
    logic [3:0] settle_cnt;
    logic [7:0] lock_cnt;
    logic [2:0] fail_cnt;
    logic       match;

    function automatic logic [2:0] sat_fail_inc(input logic [2:0] cnt);
        if (cnt >= 3'(MAX_FAILS)) begin
            return 3'(MAX_FAILS);
        end
        return cnt + 3'd1;
    endfunction

    sentinel_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (arb_update),
        .winner (arb_winner)
    );

    assign match = (core_uo == UNLOCK_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        arb_update = 1'b0;
        gnt        = 2'b00;
        done       = 2'b00;
        pass       = 1'b0;
        core_ui    = 8'h00;
        lockout    = 1'b0;
        case (state)
            IDLE: begin
                if (ena && req != 2'b00) begin
                    arb_update = 1'b1;
                    state_nxt  = DRIVE;
                end
            end
            DRIVE: begin
                gnt       = gnt_q;
                core_ui   = key_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                gnt     = gnt_q;
                core_ui = key_q;
                if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                gnt     = gnt_q;
                core_ui = key_q;
                done    = gnt_q;
                pass    = match;
                if (!match && sat_fail_inc(fail_cnt) == 3'(MAX_FAILS)) begin
                    state_nxt = LOCKOUT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOCKOUT: begin
                lockout = 1'b1;
                if (lock_cnt == 8'(LOCKOUT_CYCLES - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            lock_cnt   <= '0;
            fail_cnt   <= '0;
            gnt_q      <= '0;
        end else begin
            settle_cnt <= (state == WAIT) ? settle_cnt + 4'd1 : 4'd0;
            lock_cnt   <= (state == LOCKOUT) ? lock_cnt + 8'd1 : 8'd0;
            if (state == CAPTURE) begin
                fail_cnt <= match ? 3'd0 : sat_fail_inc(fail_cnt);
            end else if (state == LOCKOUT && state_nxt == IDLE) begin
                fail_cnt <= 3'd0;
            end
            if (arb_update) begin
                gnt_q <= arb_winner;
            end
        end
    end

    // Key is only observed through the state-gated core_ui, so it needs no reset.
    always_ff @(posedge clk) begin
        if (arb_update) begin
            key_q <= arb_winner[1] ? key1 : key0;
        end
    end

endmodule

// File: tb/tb_sentinel_access_ctrl.sv
// Directed bench for sentinel_access_ctrl with a transaction-level reference model.
module tb_sentinel_access_ctrl;

    localparam int         S    = 2;
    localparam int         L    = 16;
    localparam int         MAXF = 3;
    localparam logic [7:0] PAT  = 8'hA5;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ena     = 1'b0;
    logic [1:0] req     = 2'b00;
    logic [7:0] key0    = 8'h00;
    logic [7:0] key1    = 8'h00;
    logic [7:0] core_uo = 8'h00;
    logic [1:0] gnt, done;
    logic       pass, lockout;
    logic [7:0] core_ui;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [1:0] g_log [0:39];
    logic [1:0] d_log [0:39];
    logic       p_log [0:39];
    logic [7:0] u_log [0:39];

    always #5 clk = ~clk;

    sentinel_access_ctrl #(
        .SETTLE_CYCLES  (S),
        .UNLOCK_PATTERN (PAT),
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .key0    (key0),
        .key1    (key1),
        .gnt     (gnt),
        .done    (done),
        .pass    (pass),
        .core_ui (core_ui),
        .core_uo (core_uo),
        .lockout (lockout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 transaction in flight (m_t cycles since grant), 2 locked out.
    int         m_mode = 0;
    int         m_t = 0;
    int         m_who = 0;
    int         m_last = 1;
    int         m_fails = 0;
    int         m_lock_left = 0;
    logic [7:0] m_key = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_t = 0; m_who = 0; m_last = 1; m_fails = 0; m_lock_left = 0; m_key = 8'h00;
        end else begin
            case (m_mode)
                0: if (ena && req != 2'b00) begin
                    if (req == 2'b11) m_who = 1 - m_last;
                    else              m_who = req[1] ? 1 : 0;
                    m_last = m_who;
                    m_key  = (m_who == 1) ? key1 : key0;
                    m_t    = 0;
                    m_mode = 1;
                end
                1: if (m_t == S + 1) begin
                    if (core_uo == PAT) begin
                        m_fails = 0;
                        m_mode  = 0;
                    end else begin
                        if (m_fails < MAXF) m_fails++;
                        if (m_fails == MAXF) begin
                            m_mode = 2;
                            m_lock_left = L;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end else begin
                    m_t++;
                end
                default: begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin
                        m_mode  = 0;
                        m_fails = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] e_gnt, e_done;
        logic [7:0] e_ui;
        if (cmp_en) begin
            e_gnt  = (m_mode == 1) ? ((m_who == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_ui   = (m_mode == 1) ? m_key : 8'h00;
            e_done = (m_mode == 1 && m_t == S + 1) ? e_gnt : 2'b00;
            chk("gnt", gnt, e_gnt);
            chk("core_ui", core_ui, e_ui);
            chk("done", done, e_done);
            chk("pass", pass, (e_done != 2'b00) && (core_uo == PAT));
            chk("lockout", lockout, m_mode == 2);
        end
    end

    task automatic reset_dut(input logic [1:0] r);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = r;
        ena   = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs", {gnt, done, pass, lockout, core_ui}, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic do_txn(input logic [1:0] r, input logic [7:0] uo);
        bit seen;
        seen    = 1'b0;
        req     = r;
        core_uo = uo;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (done != 2'b00) seen = 1'b1;
        end
        chk("txn_done_seen", seen, 1);
        req = 2'b00;
    endtask

    task automatic record(input int n);
        g_log[0] = gnt; d_log[0] = done; p_log[0] = pass; u_log[0] = core_ui;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (i == 1 && req == 2'b01) req = 2'b00;
            if (i == 2) key0 = 8'h3C;
            g_log[i] = gnt; d_log[i] = done; p_log[i] = pass; u_log[i] = core_ui;
        end
    endtask

    initial begin
        int ngnt, lcnt, nst;
        int starts [0:7];

        repeat (2) @(posedge clk);
        #1;
        chk("reset_idle", {gnt, done, pass, lockout, core_ui}, 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Single passing transaction; key0 changes after latching.
        key0 = PAT; core_uo = PAT;
        reset_dut(2'b00);
        req = 2'b01;
        record(7);
        ngnt = 0;
        for (int i = 0; i <= 7; i++) if (g_log[i] == 2'b01) ngnt++;
        chk("single_gnt_cycles", ngnt, 4);
        chk("single_first_gnt", g_log[1], 2'b01);
        chk("single_done_early", d_log[3], 2'b00);
        chk("single_done_at_4", d_log[4], 2'b01);
        chk("single_pass", p_log[4], 1);
        chk("single_key_held", u_log[4], PAT);
        chk("single_ui_idle", u_log[5], 8'h00);

        // Contention with both requests held from reset.
        key0 = 8'h11; key1 = 8'h22; core_uo = PAT;
        reset_dut(2'b11);
        record(16);
        nst = 0;
        for (int i = 1; i <= 16; i++)
            if (g_log[i] != 2'b00 && g_log[i-1] == 2'b00 && nst < 8) begin
                starts[nst] = i;
                nst++;
            end
        chk("rr_num_grants", nst >= 3, 1);
        if (nst >= 3) begin
            chk("rr_grant0", g_log[starts[0]], 2'b01);
            chk("rr_grant1", g_log[starts[1]], 2'b10);
            chk("rr_grant2", g_log[starts[2]], 2'b01);
            chk("rr_gap01", starts[1] - starts[0], 5);
            chk("rr_gap12", starts[2] - starts[1], 5);
        end
        req = 2'b00;

        // Three failures lock out; req held throughout lockout is ignored.
        key0 = 8'h77;
        reset_dut(2'b00);
        repeat (3) do_txn(2'b01, 8'h00);
        req  = 2'b01;
        lcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!lockout) break;
            lcnt++;
            if (gnt != 2'b00) chk("gnt_in_lockout", gnt, 2'b00);
        end
        chk("lockout_len", lcnt, 16);
        core_uo = PAT;
        @(posedge clk); #1;
        chk("regrant_after_lockout", gnt, 2'b01);
        req = 2'b00;
        repeat (6) @(posedge clk);

        // Fail, fail, pass, fail, fail must not lock out.
        reset_dut(2'b00);
        do_txn(2'b01, 8'h00); @(posedge clk); #1; chk("no_lock_f1", lockout, 0);
        do_txn(2'b01, 8'h00); @(posedge clk); #1; chk("no_lock_f2", lockout, 0);
        do_txn(2'b01, PAT);   @(posedge clk); #1; chk("no_lock_p",  lockout, 0);
        do_txn(2'b01, 8'h00); @(posedge clk); #1; chk("no_lock_f3", lockout, 0);
        do_txn(2'b01, 8'h00); @(posedge clk); #1; chk("no_lock_f4", lockout, 0);

        // req and ena dropped in WAIT: transaction still completes.
        key1 = PAT; core_uo = PAT;
        reset_dut(2'b00);
        req = 2'b10;
        repeat (2) begin @(posedge clk); #1; end
        req = 2'b00; ena = 1'b0;
        lcnt = 0;
        for (int i = 0; i < 10 && lcnt == 0; i++) begin
            @(posedge clk); #1;
            if (done == 2'b10) lcnt = 1;
        end
        chk("drop_req_done", lcnt, 1);
        ena = 1'b1;

        // Reset asserted in WAIT aborts with all outputs low and no done.
        reset_dut(2'b00);
        req = 2'b01;
        repeat (2) begin @(posedge clk); #1; end
        chk("wait_gnt_before_rst", gnt, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("rst_in_wait_outputs", {gnt, done, pass, lockout, core_ui}, 32'h0);
        req = 2'b00;
        repeat (3) begin @(posedge clk); #1; chk("rst_no_done", done, 2'b00); end
        rst_n = 1'b1;

        // Enable gating.
        @(posedge clk); #1;
        ena = 1'b0; req = 2'b01;
        repeat (4) begin @(posedge clk); #1; chk("ena_low_no_gnt", gnt, 2'b00); end
        ena = 1'b1;
        @(posedge clk); #1;
        chk("ena_high_gnt", gnt, 2'b01);
        req = 2'b00;
        repeat (6) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
